data_ram_arbiter: RTL and testbench
===================================

// Module: data_ram_arbiter
// PURPOSE
//   Shares the single data_ram port between two masters: M0 = openmips data port
//   (ram_*_o/ram_data_i), M1 = debug/loader port. Sits between openmips and
//   data_ram in openmips_min_sopc. Registered-owner arbitration with parking,
//   bounded hold and per-master stall outputs (M0 stall feeds the ctrl stall request).
// PARAMETERS
//   ADDR_W    32  address width (RegBus)
//   DATA_W    32  data width (RegBus)
//   MAX_HOLD  4   max consecutive contended cycles owner keeps the port (>=1)
// PORTS
//   clk          in   1       system clock
//   rst          in   1       synchronous reset, active high
//   m0_ce_i      in   1       M0 access request
//   m0_we_i      in   1       M0 write enable
//   m0_addr_i    in   ADDR_W  M0 address
//   m0_sel_i     in   4       M0 byte select
//   m0_data_i    in   DATA_W  M0 write data
//   m0_data_o    out  DATA_W  M0 read data
//   m0_stall_o   out  1       M0 must hold request, not served this cycle
//   m1_*         --   --      same seven ports for M1
//   ram_ce_o     out  1       to data_ram ce
//   ram_we_o     out  1       to data_ram we
//   ram_addr_o   out  ADDR_W  to data_ram addr
//   ram_sel_o    out  4       to data_ram sel
//   ram_data_o   out  DATA_W  to data_ram data_i
//   ram_data_i   in   DATA_W  from data_ram data_o (combinational read)
//   owner_o      out  1       current owner (0=M0, 1=M1)
// BEHAVIOUR
//   - State: owner reg (OWN0/OWN1), hold_cnt reg ($clog2(MAX_HOLD+1) bits).
//   - Reset (rst=1 at edge): owner<=OWN0, hold_cnt<=0. While rst=1 all outputs 0
//     (ram_ce_o=0, ram_we_o=0, stalls=0, data_o=0, owner_o=0).
//   - Datapath (combinational from owner): ram_ce_o = ce of owner; when owner ce=1
//     ram_we/addr/sel/data = owner's inputs, else all 0 (ram_we_o never 1 with ce 0).
//   - Served master: mX_data_o = ram_data_i when owner==X and mX_ce_i=1, else 0.
//   - mX_stall_o = mX_ce_i & (owner!=X). Non-owner inputs ignored; never reach RAM.
//   - Latency: owner access served same cycle (0 wait). Non-owner request waits
//     >=1 cycle (switch happens at edge, served next cycle).
//   - Transitions at each edge (o=owner, n=other):
//       n_ce=0                    : stay, hold_cnt<=0 (parking on last owner)
//       o_ce=0, n_ce=1            : owner<=n, hold_cnt<=0
//       o_ce=1, n_ce=1, cnt<MAX_HOLD-1 : stay, hold_cnt<=hold_cnt+1
//       o_ce=1, n_ce=1, cnt==MAX_HOLD-1: owner<=n, hold_cnt<=0
//   - Contended access: owner gets exactly MAX_HOLD served cycles, then loser is
//     guaranteed the port -> worst-case wait MAX_HOLD cycles, no starvation.
//   - Write in switch cycle commits to RAM at that edge from old owner; new owner
//     drives RAM from next cycle. No access lost or duplicated.
//   - Masters must hold ce/we/addr/sel/data stable while stall_o=1.
//   - Reset mid-hold: owner forced to OWN0, counter cleared; pending M1 stalls.
// TESTING
//   1 rst=1 two cycles, M1 ce=1 -> all outputs 0; after release owner_o=0, m1 stall=1.
//   2 M0 only, write 0xDEADBEEF @0x10 sel=1111 then read @0x10 -> no stall,
//     m0_data_o=0xDEADBEEF next read cycle.
//   3 owner=M0 parked, M0 idle, M1 read @0x10 -> 1 stall cycle, served cycle 2,
//     owner_o=1; M1 stays parked after ce drops (next M1 access 0 wait).
//   4 both ce=1 continuous, MAX_HOLD=4 -> owner_o pattern 0,0,0,0,1,1,1,1,0...;
//     each stall_o high exactly 4 cycles per window; ram_* track owner.
//   5 M0 writes 0x11223344 sel=0011 in switch cycle, M1 reads same addr next ->
//     M1 sees byte-merged value; M1's ungranted write never reaches RAM.
//   6 rst asserted while owner=M1 hold_cnt=2 -> next cycle owner_o=0, hold_cnt=0.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// Two-master arbiter for the single data_ram port (M0 = CPU data port, M1 = debug/loader).
// Latency: owner served combinationally in the same cycle; a non-owner waits at least one edge.
// Backpressure: the non-owner sees stall while requesting; contended owner yields after MAX_HOLD cycles.
module data_ram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_ce_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_stall_o,
  input  logic              m1_ce_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_stall_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              owner_o
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} owner_t;

  owner_t          owner;
  logic [CW-1:0]   hold_cnt;
  logic            own_ce;
  logic            oth_ce;

  // Request of the current owner and of the other master.
  always_comb begin
    own_ce = (owner == OWN1) ? m1_ce_i : m0_ce_i;
    oth_ce = (owner == OWN1) ? m0_ce_i : m1_ce_i;
  end

  // Ownership: park on last owner when uncontended, hand over on idle owner
  // or once the owner has used its MAX_HOLD contended cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= OWN0;
      hold_cnt <= '0;
    end else if (!oth_ce) begin
      hold_cnt <= '0;
    end else if (!own_ce || hold_cnt == HOLD_LAST) begin
      owner    <= (owner == OWN1) ? OWN0 : OWN1;
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // RAM mux and per-master return path; everything forced low during reset
  // and the RAM bus is zeroed whenever the owner is idle.
  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    m0_data_o  = '0;
    m1_data_o  = '0;
    m0_stall_o = 1'b0;
    m1_stall_o = 1'b0;
    owner_o    = 1'b0;
    if (!rst) begin
      owner_o    = (owner == OWN1);
      m0_stall_o = m0_ce_i && (owner != OWN0);
      m1_stall_o = m1_ce_i && (owner != OWN1);
      if (owner == OWN0 && m0_ce_i) begin
        ram_ce_o   = 1'b1;
        ram_we_o   = m0_we_i;
        ram_addr_o = m0_addr_i;
        ram_sel_o  = m0_sel_i;
        ram_data_o = m0_data_i;
        m0_data_o  = ram_data_i;
      end else if (owner == OWN1 && m1_ce_i) begin
        ram_ce_o   = 1'b1;
        ram_we_o   = m1_we_i;
        ram_addr_o = m1_addr_i;
        ram_sel_o  = m1_sel_i;
        ram_data_o = m1_data_i;
        m1_data_o  = ram_data_i;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed scenarios plus randomized two-master traffic.
// Outputs are compared each cycle against a behavioural model of ownership and memory contents.
// Masters hold their request while stalled; the bench provides the combinational-read RAM.
module tb_data_ram_arbiter;

  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_ce_i, m0_we_i, m1_ce_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_stall_o, m1_stall_o;
  logic        ram_ce_o, ram_we_o, owner_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel_o;

  data_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .m0_ce_i(m0_ce_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_sel_i(m0_sel_i),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_stall_o(m0_stall_o),
    .m1_ce_i(m1_ce_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_sel_i(m1_sel_i),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_stall_o(m1_stall_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
    .owner_o(owner_o)
  );

  always #5 clk = ~clk;

  // Eight-word data RAM: combinational read, byte-enabled write at the edge.
  logic [31:0] mem [0:7];
  assign ram_data_i = mem[ram_addr_o[4:2]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'(i) * 32'h01010101;
    end else if (ram_ce_o && ram_we_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel_o[b]) mem[ram_addr_o[4:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port and how many contended cycles it has used.
  int          m_own = 0;
  int          m_run = 0;
  logic [31:0] exp_mem [0:7];

  logic        obs_owner, obs_m0_stall, obs_m1_stall;
  logic [31:0] obs_m0_data, obs_m1_data;

  // One clock cycle: drive, check against model, advance model, cross the edge.
  task automatic cyc(input logic r, input logic [1:0] ce, input logic [1:0] we,
                     input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] d0,
                     input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1);
    logic [31:0] a [2];
    logic [3:0]  s [2];
    logic [31:0] d [2];
    logic [31:0] e_data [2];
    logic        e_stall [2];
    logic        oc;
    int          oth;
    a[0] = a0; a[1] = a1; s[0] = s0; s[1] = s1; d[0] = d0; d[1] = d1;
    rst = r;
    m0_ce_i = ce[0]; m0_we_i = we[0]; m0_addr_i = a0; m0_sel_i = s0; m0_data_i = d0;
    m1_ce_i = ce[1]; m1_we_i = we[1]; m1_addr_i = a1; m1_sel_i = s1; m1_data_i = d1;
    #1;
    oc  = ce[m_own];
    oth = 1 - m_own;
    for (int x = 0; x < 2; x++) begin
      e_stall[x] = !r && ce[x] && (m_own != x);
      e_data[x]  = (!r && m_own == x && ce[x]) ? exp_mem[a[x][4:2]] : 32'h0;
    end
    if (r) begin
      chk("owner",    {31'h0, owner_o},  32'h0);
      chk("ram_ce",   {31'h0, ram_ce_o}, 32'h0);
      chk("ram_we",   {31'h0, ram_we_o}, 32'h0);
      chk("ram_addr", ram_addr_o,        32'h0);
      chk("ram_sel",  {28'h0, ram_sel_o},32'h0);
      chk("ram_wdat", ram_data_o,        32'h0);
    end else begin
      chk("owner",    {31'h0, owner_o},  32'(m_own));
      chk("ram_ce",   {31'h0, ram_ce_o}, {31'h0, oc});
      chk("ram_we",   {31'h0, ram_we_o}, {31'h0, oc && we[m_own]});
      chk("ram_addr", ram_addr_o,        oc ? a[m_own] : 32'h0);
      chk("ram_sel",  {28'h0, ram_sel_o},oc ? {28'h0, s[m_own]} : 32'h0);
      chk("ram_wdat", ram_data_o,        oc ? d[m_own] : 32'h0);
    end
    chk("m0_data",  m0_data_o, e_data[0]);
    chk("m1_data",  m1_data_o, e_data[1]);
    chk("m0_stall", {31'h0, m0_stall_o}, {31'h0, e_stall[0]});
    chk("m1_stall", {31'h0, m1_stall_o}, {31'h0, e_stall[1]});
    obs_owner = owner_o; obs_m0_stall = m0_stall_o; obs_m1_stall = m1_stall_o;
    obs_m0_data = m0_data_o; obs_m1_data = m1_data_o;
    if (r) begin
      m_own = 0;
      m_run = 0;
      for (int i = 0; i < 8; i++) exp_mem[i] = 32'(i) * 32'h01010101;
    end else begin
      if (oc && we[m_own])
        for (int b = 0; b < 4; b++)
          if (s[m_own][b]) exp_mem[a[m_own][4:2]][8*b +: 8] = d[m_own][8*b +: 8];
      if (!ce[oth]) begin
        m_run = 0;
      end else if (!oc || m_run + 1 >= MAX_HOLD) begin
        m_own = oth;
        m_run = 0;
      end else begin
        m_run = m_run + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic        rc [2];
  logic        rw [2];
  logic [31:0] ra [2];
  logic [3:0]  rs [2];
  logic [31:0] rd [2];

  initial begin
    for (int i = 0; i < 8; i++) exp_mem[i] = 32'(i) * 32'h01010101;
    @(negedge clk);

    // Reset with M1 requesting: everything low; after release M1 is stalled behind M0.
    cyc(1, 2'b10, 2'b00, 0, 0, 0, 32'h10, 4'hF, 0);
    cyc(1, 2'b10, 2'b00, 0, 0, 0, 32'h10, 4'hF, 0);
    chk("rst_m1_stall", {31'h0, obs_m1_stall}, 32'h0);
    cyc(0, 2'b10, 2'b00, 0, 0, 0, 32'h10, 4'hF, 0);
    chk("rel_owner", {31'h0, obs_owner}, 32'h0);
    chk("rel_m1_stall", {31'h0, obs_m1_stall}, 32'h1);
    cyc(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);

    // M0 alone: write then read back with no waits.
    cyc(0, 2'b01, 2'b01, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0);
    chk("m0_wr_stall", {31'h0, obs_m0_stall}, 32'h0);
    cyc(0, 2'b01, 2'b00, 32'h10, 4'hF, 0, 0, 0, 0);
    chk("m0_rd_data", obs_m0_data, 32'hDEADBEEF);

    // M1 takes the parked port after one stall and keeps it parked.
    cyc(0, 2'b10, 2'b00, 0, 0, 0, 32'h10, 4'hF, 0);
    chk("m1_first_stall", {31'h0, obs_m1_stall}, 32'h1);
    cyc(0, 2'b10, 2'b00, 0, 0, 0, 32'h10, 4'hF, 0);
    chk("m1_served_owner", {31'h0, obs_owner}, 32'h1);
    chk("m1_served_data", obs_m1_data, 32'hDEADBEEF);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc(0, 2'b10, 2'b00, 0, 0, 0, 32'h10, 4'hF, 0);
    chk("m1_parked_stall", {31'h0, obs_m1_stall}, 32'h0);
    chk("m1_parked_data", obs_m1_data, 32'hDEADBEEF);

    // Continuous contention: ownership alternates in windows of MAX_HOLD.
    cyc(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 2'b11, 2'b00, 32'h4, 4'hF, 0, 32'hC, 4'hF, 0);
      chk("rr_owner", {31'h0, obs_owner}, 32'((i / MAX_HOLD) % 2));
    end

    // Byte-merged write in the switch cycle is visible to the new owner.
    cyc(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 2'b11, 2'b00, 32'h0, 4'hF, 0, 32'h8, 4'hF, 0);
    cyc(0, 2'b11, 2'b01, 32'h8, 4'b0011, 32'h11223344, 32'h8, 4'hF, 0);
    cyc(0, 2'b11, 2'b00, 32'h0, 4'hF, 0, 32'h8, 4'hF, 0);
    chk("merge_m1_data", obs_m1_data, 32'h02023344);

    // A stalled M1 write never reaches the RAM.
    cyc(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc(0, 2'b01, 2'b00, 32'h8, 4'hF, 0, 0, 0, 0);
    cyc(0, 2'b11, 2'b10, 32'h8, 4'hF, 0, 32'h8, 4'hF, 32'hBADBAD00);
    cyc(0, 2'b01, 2'b00, 32'h8, 4'hF, 0, 0, 0, 0);
    chk("nolead_m0_data", obs_m0_data, 32'h02020202);

    // Reset in the middle of an M1 hold window restarts from M0 with a cleared count.
    cyc(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 2'b11, 2'b00, 32'h4, 4'hF, 0, 32'hC, 4'hF, 0);
    chk("pre_rst_owner", {31'h0, obs_owner}, 32'h1);
    cyc(1, 2'b11, 2'b00, 32'h4, 4'hF, 0, 32'hC, 4'hF, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 2'b11, 2'b00, 32'h4, 4'hF, 0, 32'hC, 4'hF, 0);
      chk("post_rst_owner", {31'h0, obs_owner}, (i < MAX_HOLD) ? 32'h0 : 32'h1);
    end

    // Randomized traffic; stalled masters keep their request unchanged.
    for (int x = 0; x < 2; x++) begin
      rc[x] = 0; rw[x] = 0; ra[x] = 0; rs[x] = 0; rd[x] = 0;
    end
    for (int i = 0; i < 600; i++) begin
      int  pct;
      logic r;
      pct = ((i / 50) % 2 == 1) ? 90 : 40;
      for (int x = 0; x < 2; x++) begin
        if (!(rc[x] && m_own != x)) begin
          rc[x] = ($urandom_range(0, 99) < pct);
          rw[x] = 1'($urandom_range(0, 1));
          ra[x] = 32'($urandom_range(0, 7)) << 2;
          rs[x] = 4'($urandom_range(0, 15));
          rd[x] = $urandom;
        end
      end
      r = ($urandom_range(0, 199) == 0);
      cyc(r, {rc[1], rc[0]}, {rw[1], rw[0]}, ra[0], rs[0], rd[0], ra[1], rs[1], rd[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
